// File: rtl/key_mode_controller.sv
// Debounced two-button mode selector: sync -> debounce -> press detect -> 2-bit mode step/home.
// Optional idle auto-advance is enabled with `define MODE_AUTOCYCLE_EN.
module key_mode_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_CYCLES     = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] key,
   output logic [1:0] mode,
   output logic       mode_changed,
   output logic [1:0] key_state
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [1:0] meta_q, meta_d;
   logic [1:0] sync_q, sync_d;
   logic [1:0] state_q, state_d;
   logic [1:0] state_dly_q, state_dly_d;
   logic [1:0] press_q, press_d;
   logic [1:0] mode_q, mode_d;
   logic       mode_changed_q, mode_changed_d;
   logic       tick;

   always_comb begin
      meta_d      = key;
      sync_d      = meta_q;
      state_dly_d = state_q;
      press_d     = state_q & ~state_dly_q;
   end

   // Accepted levels are kept active-high; the raw keys are active-low.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
         logic [DW-1:0] cnt_q, cnt_d;
         logic          level_d;

         always_comb begin
            cnt_d   = cnt_q;
            level_d = state_q[gi];
            if (~sync_q[gi] == state_q[gi]) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               cnt_d   = '0;
               level_d = ~state_q[gi];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         assign state_d[gi] = level_d;

         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

`ifdef MODE_AUTOCYCLE_EN
   localparam int AW = $clog2(AUTO_CYCLES + 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

   logic [AW-1:0] idle_q, idle_d;

   // A key press restarts the idle period and suppresses a coincident tick.
   always_comb begin
      tick   = 1'b0;
      idle_d = idle_q + 1'b1;
      if (|press_q) begin
         idle_d = '0;
      end else if (idle_q == AUTO_LAST) begin
         idle_d = '0;
         tick   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   // AUTO_CYCLES is always >= 1, so this is a constant 0 without the auto feature.
   assign tick = (AUTO_CYCLES < 1);
`endif

   always_comb begin
      mode_d = mode_q;
      if (press_q == 2'b11) begin
         mode_d = 2'd0;
      end else if (press_q[0]) begin
         mode_d = mode_q + 2'd1;
      end else if (press_q[1]) begin
         mode_d = mode_q - 2'd1;
      end else if (tick) begin
         mode_d = mode_q + 2'd1;
      end
      mode_changed_d = (mode_d != mode_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q         <= 2'b11;
         sync_q         <= 2'b11;
         state_q        <= 2'b00;
         state_dly_q    <= 2'b00;
         press_q        <= 2'b00;
         mode_q         <= 2'd0;
         mode_changed_q <= 1'b0;
      end else begin
         meta_q         <= meta_d;
         sync_q         <= sync_d;
         state_q        <= state_d;
         state_dly_q    <= state_dly_d;
         press_q        <= press_d;
         mode_q         <= mode_d;
         mode_changed_q <= mode_changed_d;
      end
   end

   assign mode         = mode_q;
   assign mode_changed = mode_changed_q;
   assign key_state    = state_q;

endmodule

// File: tb/tb_key_mode_controller.sv
// Directed bench for key_mode_controller with DEBOUNCE_CYCLES=4, AUTO_CYCLES=20.
// With MODE_AUTOCYCLE_EN defined it exercises the idle auto-advance instead.
module tb_key_mode_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] key = 2'b11;
   logic [1:0] mode;
   logic       mode_changed;
   logic [1:0] key_state;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   logic [1:0] state_seen;

   typedef struct {
      logic [1:0] key;
      int         cycles;
      logic [1:0] exp_mode;
      logic [1:0] exp_state;
      int         exp_pulses;
   } vec_t;

   vec_t vecs[18];

   key_mode_controller #(
      .DEBOUNCE_CYCLES(4),
      .AUTO_CYCLES    (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key         (key),
      .mode        (mode),
      .mode_changed(mode_changed),
      .key_state   (key_state)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and sample 1 ns after it.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (mode_changed) pulses++;
         state_seen = state_seen | key_state;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   initial begin
      state_seen = 2'b00;
      vecs = '{
         '{2'b10,  8, 2'd2, 2'b01, 1},
         '{2'b11,  8, 2'd2, 2'b00, 0},
         '{2'b10,  8, 2'd3, 2'b01, 1},
         '{2'b11,  8, 2'd3, 2'b00, 0},
         '{2'b10,  8, 2'd0, 2'b01, 1},
         '{2'b11,  8, 2'd0, 2'b00, 0},
         '{2'b01,  8, 2'd3, 2'b10, 1},
         '{2'b11,  8, 2'd3, 2'b00, 0},
         '{2'b10, 30, 2'd0, 2'b01, 1},
         '{2'b11,  8, 2'd0, 2'b00, 0},
         '{2'b10,  8, 2'd1, 2'b01, 1},
         '{2'b11,  8, 2'd1, 2'b00, 0},
         '{2'b10,  8, 2'd2, 2'b01, 1},
         '{2'b11,  8, 2'd2, 2'b00, 0},
         '{2'b00,  8, 2'd0, 2'b11, 1},
         '{2'b11,  8, 2'd0, 2'b00, 0},
         '{2'b00,  8, 2'd0, 2'b11, 0},
         '{2'b11,  8, 2'd0, 2'b00, 0}
      };

      reset = 1'b1;
      key   = 2'b11;
      step(3);
      chk("reset_mode", int'(mode), 0);
      chk("reset_key_state", int'(key_state), 0);
      chk("reset_mode_changed", int'(mode_changed), 0);
      reset = 1'b0;

`ifdef MODE_AUTOCYCLE_EN
      step(19);
      chk("auto_before_first_tick", int'(mode), 0);
      step(1);
      chk("auto_first_tick_mode", int'(mode), 1);
      chk("auto_first_tick_pulse", int'(mode_changed), 1);
      step(20);
      chk("auto_second_tick_mode", int'(mode), 2);
      step(12);
      key = 2'b10;
      step(7);
      chk("auto_before_collision", int'(mode), 2);
      step(1);
      key = 2'b11;
      chk("auto_collision_single_step", int'(mode), 3);
      chk("auto_collision_pulse", int'(mode_changed), 1);
      step(19);
      chk("auto_restart_hold", int'(mode), 3);
      step(1);
      chk("auto_restart_tick", int'(mode), 0);
`else
      // First press: exact latency 2 + 4 + 2 edges.
      key = 2'b10;
      step(7);
      chk("latency_mode_before", int'(mode), 0);
      step(1);
      chk("latency_mode_after", int'(mode), 1);
      chk("latency_pulse_high", int'(mode_changed), 1);
      step(1);
      chk("latency_pulse_low", int'(mode_changed), 0);
      step(1);
      chk("held_key_state", int'(key_state), 1);
      key = 2'b11;
      step(8);
      chk("release_key_state", int'(key_state), 0);
      chk("release_mode", int'(mode), 1);

      foreach (vecs[v]) begin
         pulses = 0;
         key = vecs[v].key;
         step(vecs[v].cycles);
         chk($sformatf("vec%0d_mode", v), int'(mode), int'(vecs[v].exp_mode));
         chk($sformatf("vec%0d_key_state", v), int'(key_state), int'(vecs[v].exp_state));
         chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      end

      // Bounce: 3-cycle pulses never reach the 4-cycle threshold.
      pulses = 0;
      state_seen = 2'b00;
      for (int b = 0; b < 5; b++) begin
         key = 2'b10;
         step(3);
         key = 2'b11;
         step(3);
      end
      step(10);
      chk("bounce_key_state_seen", int'(state_seen), 0);
      chk("bounce_pulses", pulses, 0);
      chk("bounce_mode", int'(mode), 0);

      // Offset presses one cycle apart: step up then down.
      pulses = 0;
      key = 2'b10;
      step(1);
      key = 2'b00;
      step(9);
      chk("offset_pulses", pulses, 2);
      chk("offset_mode", int'(mode), 0);
      key = 2'b11;
      step(8);

      key = 2'b10;
      step(8);
      key = 2'b11;
      step(8);
      chk("pre_reset_mode", int'(mode), 1);

      // Reset while key0 has been stable at the synchroniser for 2 cycles.
      key = 2'b10;
      step(4);
      reset = 1'b1;
      step(1);
      chk("midreset_mode", int'(mode), 0);
      chk("midreset_key_state", int'(key_state), 0);
      chk("midreset_mode_changed", int'(mode_changed), 0);
      reset = 1'b0;
      pulses = 0;
      step(20);
      chk("post_reset_mode", int'(mode), 1);
      chk("post_reset_pulses", pulses, 1);
      step(20);
      chk("post_reset_no_repeat", pulses, 1);
      key = 2'b11;
      step(8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_mode_controller.md
# key_mode_controller

Synchronous controller that turns the two board push-buttons into a debounced, glitch-free 2-bit display-mode selector. Raw active-low keys are synchronised to `clk`, debounced, edge-detected and fed to a mode sequencer that steps forward, steps back or homes the mode. Its `mode` output drives the mode-select input of the display/datapath logic, replacing edge-clocked toggling with a single-clock-domain design.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz); legal range ≥1.
- `AUTO_CYCLES`, 100000000: idle period before auto-advance (only used with `MODE_AUTOCYCLE_EN`); legal range ≥1.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `key`  input  2  raw push-buttons, active-low (0 = pressed), asynchronous to `clk`.
- `mode`  output  2  current mode, 0–3.
- `mode_changed`  output  1  one-cycle pulse, high in the same cycle `mode` first shows a new value.
- `key_state`  output  2  debounced key levels, active-high (1 = pressed).

## Operation
- Synchroniser: per key, two flops; reset value 1 (released).
- Debouncer, per key:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised level equals the accepted level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the accepted level flips and the counter clears.
  - Reset: accepted = released, counter = 0.
- Press detect: `press[i]` is a registered one-cycle pulse when accepted level i goes released→pressed. Releases generate no event.
- Mode sequencer, evaluated each cycle in priority order:
  1. `press[0]` and `press[1]` both high: mode ← 0.
  2. `press[0]` only: mode ← mode+1, mod 4 (3→0 wraps).
  3. `press[1]` only: mode ← mode−1, mod 4 (0→3 wraps).
  4. Auto-advance tick (macro only): mode ← mode+1, mod 4.
  5. Otherwise: hold.
- `mode_changed`:
  - Asserted only when the new mode differs from the old one.
  - Case 1 with mode already 0 produces no pulse.
- A key held down produces exactly one event; there is no auto-repeat.
- Reset values: `mode`=0, `mode_changed`=0, `key_state`=00, `press`=00, all counters 0.
- Reset asserted mid-debounce or mid-count: every register returns to its reset value on that edge. A key still held when reset deasserts is re-debounced and generates one press.

## Timing
- Raw key change to synchroniser output: 2 cycles.
- Synchroniser output held stable for DEBOUNCE_CYCLES cycles: accepted level flips on the DEBOUNCE_CYCLES-th edge; `key_state` updates on that same edge.
- `press` pulse: 1 cycle after the accepted-level flip.
- `mode`/`mode_changed`: 1 cycle after `press`.
- Total, clean key edge to `mode` update: 2 + DEBOUNCE_CYCLES + 2 cycles.
- Bounce shorter than DEBOUNCE_CYCLES cycles restarts the count and produces no event.
- Simultaneous press is resolved per cycle. Both accepted levels must flip on the same edge to home the mode. Offset presses are treated as two separate steps.

## Configuration
- `MODE_AUTOCYCLE_EN` defined:
  - Adds an idle counter of width $clog2(AUTO_CYCLES+1).
  - The counter clears on reset and on any `press` pulse.
  - When it reaches AUTO_CYCLES it issues a one-cycle tick and clears.
  - A tick in the same cycle as a `press` is dropped; the key wins and the counter clears.
- Not defined: no idle counter; `mode` changes only on key events; `AUTO_CYCLES` is ignored.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, AUTO_CYCLES=20.
- Reset, then clean `key`=2'b10 held for 10 cycles → `key_state`=01; `mode` 0→1 exactly 8 cycles after the key edge, with a one-cycle `mode_changed`.
- Four clean key0 presses from mode 0 → mode sequence 1,2,3,0. Then one key1 press → mode 3 (wrap-down).
- key0 bouncing with 3-cycle pulses for 30 cycles, then held released → `key_state`=00 throughout, `mode` unchanged, no `mode_changed`.
- Both keys fall on the same cycle while mode=2 → mode 0 after 2+4+2 cycles, one pulse. Repeat at mode 0 → no pulse.
- Assert `reset` while key0 has been stable for 2 cycles → all outputs 0 next cycle. Key still held after reset → exactly one increment after debounce.
- `MODE_AUTOCYCLE_EN` defined, no keys pressed → mode increments every 20 cycles with a pulse each time. With a press timed to coincide with a tick, only one increment occurs and the next tick comes 20 cycles later.
